// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch handshake between the multicycle core and its instruction memory.
// Signal names are given from the core's point of view.
interface multicycle_cpu_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_valid_i;
  logic [31:0]     imem_instr_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_valid_i,
    input  imem_instr_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_valid_i,
    output imem_instr_i
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Sequential RV-subset core: FETCH -> EXEC -> WB, one instruction in flight,
// halts on any illegal encoding or out-of-range register address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request PC from imem, wait (unbounded) for valid, latch IR
// S_EXEC  | decode IR, read rs1/rs2, register ALU result and next PC
// S_WB    | write rd (if any), update PC, pulse retire
// S_HALT  | illegal instruction seen; frozen until reset
module multicycle_cpu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     NREGS    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_cpu_if.master imem,
  output logic             retire_o,
  output logic [XLEN-1:0]  retire_pc_o,
  output logic             wb_en_o,
  output logic [4:0]       wb_addr_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             halted_o
);

  localparam int unsigned     SHW  = $clog2(XLEN);
  localparam int unsigned     AW   = $clog2(NREGS);
  localparam logic [6:0]      OP_R = 7'b0110011;
  localparam logic [6:0]      OP_I = 7'b0010011;
  localparam logic [6:0]      OP_B = 7'b1100011;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_e;

  state_e          state_q, state_d;
  logic            rst_sync_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [31:0]     ir_q, ir_d;
  logic            wr_q, wr_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] regs_q [NREGS];

  // Reset release is retimed so the first edge after deassertion never accepts a fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_b;
  logic [SHW-1:0]  sh_r, sh_i;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1[AW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2[AW-1:0]];
  assign sh_r    = rs2_val[SHW-1:0];
  assign sh_i    = ir_q[20 +: SHW];

  function automatic logic bad_reg(input logic [4:0] a);
    return {1'b0, a} >= 6'(NREGS);
  endfunction

  logic            illegal, writes, taken, sh_hi_bad;
  logic [XLEN-1:0] alu;

  // On RV32 an immediate shift with imm[5] set has no meaning.
  assign sh_hi_bad = (XLEN == 32) && ir_q[25];

  always_comb begin
    illegal = 1'b0;
    writes  = 1'b0;
    taken   = 1'b0;
    alu     = '0;
    case (opcode)
      OP_R: begin
        writes  = 1'b1;
        illegal = bad_reg(rs1) || bad_reg(rs2) || bad_reg(rd);
        case ({funct7, funct3})
          {7'h00, 3'b000}: alu = rs1_val + rs2_val;
          {7'h20, 3'b000}: alu = rs1_val - rs2_val;
          {7'h00, 3'b001}: alu = rs1_val << sh_r;
          {7'h00, 3'b010}: alu = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
          {7'h00, 3'b100}: alu = rs1_val ^ rs2_val;
          {7'h00, 3'b101}: alu = rs1_val >> sh_r;
          {7'h20, 3'b101}: alu = $signed(rs1_val) >>> sh_r;
          {7'h00, 3'b110}: alu = rs1_val | rs2_val;
          {7'h00, 3'b111}: alu = rs1_val & rs2_val;
          default:         illegal = 1'b1;
        endcase
      end
      OP_I: begin
        writes  = 1'b1;
        illegal = bad_reg(rs1) || bad_reg(rd);
        case (funct3)
          3'b000: alu = rs1_val + imm_i;
          3'b100: alu = rs1_val ^ imm_i;
          3'b110: alu = rs1_val | imm_i;
          3'b111: alu = rs1_val & imm_i;
          3'b001: begin
            alu = rs1_val << sh_i;
            if (ir_q[31:26] != 6'b000000 || sh_hi_bad) illegal = 1'b1;
          end
          3'b101: begin
            if (ir_q[31:26] == 6'b000000)      alu = rs1_val >> sh_i;
            else if (ir_q[31:26] == 6'b010000) alu = $signed(rs1_val) >>> sh_i;
            else                               illegal = 1'b1;
            if (sh_hi_bad) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_B: begin
        illegal = bad_reg(rs1) || bad_reg(rs2);
        case (funct3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    res_d   = res_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    case (state_q)
      S_FETCH: begin
        if (rst_sync_q && imem.imem_valid_i) begin
          ir_d    = imem.imem_instr_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (illegal) begin
          state_d = S_HALT;
        end else begin
          res_d   = alu;
          wr_d    = writes && (rd != 5'd0);
          rd_d    = rd;
          npc_d   = taken ? (pc_q + imm_b) : (pc_q + FOUR);
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      npc_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && wr_q) begin
      regs_q[rd_q[AW-1:0]] <= res_q;
    end
  end

  assign imem.imem_req_o  = (state_q == S_FETCH) && rst_sync_q;
  assign imem.imem_addr_o = pc_q;
  assign retire_o         = (state_q == S_WB);
  assign retire_pc_o      = retire_o ? pc_q : '0;
  assign wb_en_o          = retire_o && wr_q;
  assign wb_addr_o        = wb_en_o ? rd_q : 5'd0;
  assign wb_data_o        = wb_en_o ? res_q : '0;
  assign halted_o         = (state_q == S_HALT);

endmodule
